regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wr_arb.sv | 49 ++++
 rtl/regfile_mp.sv | 163 ++++++++++++++++
 tb/tb_regfile_mp.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg -- shared types and default sizes for the multi-port regfile
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_REG_COUNT  = 32;
  localparam int DEF_NUM_RD     = 2;
  localparam int DEF_NUM_WR     = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wr_arb.sv
// ============================================================================
// regfile_wr_arb -- per-register write arbitration, highest port index wins
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int NUM_WR     = DEF_NUM_WR
) (
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data,
  input  logic                           accept,
  output logic [REG_COUNT-1:0]           reg_we,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_wd
);

  genvar r;
  generate
    for (r = 0; r < REG_COUNT; r++) begin : g_reg
      logic                  we_r;
      logic [DATA_WIDTH-1:0] wd_r;

      // Ascending scan: a later (higher) port overrides any earlier match.
      always_comb begin
        we_r = 1'b0;
        wd_r = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (accept && wr_en[p] &&
              (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
            we_r = 1'b1;
            wd_r = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      assign reg_we[r]                          = we_r;
      assign reg_wd[r*DATA_WIDTH +: DATA_WIDTH] = wd_r;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp -- multi-port register file with pending scoreboard and bulk clear
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int NUM_WR     = DEF_NUM_WR
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_pending,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  logic [DATA_WIDTH-1:0] data_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] data_d [REG_COUNT];
  logic [REG_COUNT-1:0]  pend_q, pend_d;
  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  done_q, done_d;

  logic                            idle;
  logic [REG_COUNT-1:0]            reg_we;
  logic [REG_COUNT*DATA_WIDTH-1:0] reg_wd;
  logic [REG_COUNT-1:0]            rsv_hit;

  assign idle = (state_q == IDLE);

  // Writes are only accepted in IDLE, so reg_we also qualifies the read bypass.
  regfile_wr_arb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .NUM_WR     (NUM_WR)
  ) u_wr_arb (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .accept  (idle),
    .reg_we  (reg_we),
    .reg_wd  (reg_wd)
  );

  genvar g;
  generate
    for (g = 0; g < REG_COUNT; g++) begin : g_rsv
      assign rsv_hit[g] = idle && rsv_en && (rsv_addr == ADDR_WIDTH'(g));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == ADDR_WIDTH'(REG_COUNT - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Reservation beats a same-cycle write; the clear sweep beats everything.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      data_d[r] = data_q[r];
      pend_d[r] = pend_q[r];
      if (reg_we[r]) begin
        data_d[r] = reg_wd[r*DATA_WIDTH +: DATA_WIDTH];
        pend_d[r] = 1'b0;
      end
      if (rsv_hit[r]) begin
        pend_d[r] = 1'b1;
      end
      if (!idle && (idx_q == ADDR_WIDTH'(r))) begin
        data_d[r] = '0;
        pend_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      pend_q  <= '0;
      for (int r = 0; r < REG_COUNT; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      for (int r = 0; r < REG_COUNT; r++) begin
        data_q[r] <= data_d[r];
      end
    end
  end

  // Addresses at or above REG_COUNT match no register and read back as zero.
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] val;
      logic                  pnd;

      assign addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
        val = '0;
        pnd = 1'b0;
        for (int r = 0; r < REG_COUNT; r++) begin
          if (addr == ADDR_WIDTH'(r)) begin
            val = reg_we[r] ? reg_wd[r*DATA_WIDTH +: DATA_WIDTH] : data_q[r];
            pnd = pend_q[r];
          end
        end
      end

      assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = val;
      assign rd_pending[g]                       = pnd;
    end
  endgenerate

  assign clr_busy = !idle;
  assign clr_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp -- directed scoreboard bench for regfile_mp (default + wide build)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int K_RD0 = 0, K_RD1 = 1, K_PD0 = 2, K_PD1 = 3, K_BUSY = 4, K_DONE = 5;
  localparam int K2_RD0 = 6, K2_PD0 = 10, K2_BUSY = 14, K2_DONE = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_pending;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        clr_req;
  logic        clr_busy, clr_done;

  logic [2:0]   wr_en2;
  logic [14:0]  wr_addr2;
  logic [95:0]  wr_data2;
  logic [19:0]  rd_addr2;
  logic [127:0] rd_data2;
  logic [3:0]   rd_pending2;
  logic         rsv_en2;
  logic [4:0]   rsv_addr2;
  logic         clr_req2;
  logic         clr_busy2, clr_done2;

  regfile_mp dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_COUNT(24), .NUM_RD(4), .NUM_WR(3)
  ) dut2 (
    .clk(clk), .nrst(nrst), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_pending(rd_pending2),
    .rsv_en(rsv_en2), .rsv_addr(rsv_addr2), .clr_req(clr_req2),
    .clr_busy(clr_busy2), .clr_done(clr_done2)
  );

  // Scoreboard: stimulus pushes expectations, monitor drains them at negedge.
  int          kq[$];
  logic [31:0] eq[$];
  string       nq[$];
  int          errors = 0;
  int          checks = 0;

  task automatic push_chk(input int k, input logic [31:0] v, input string n);
    kq.push_back(k);
    eq.push_back(v);
    nq.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RD0:   return {16'h0, rd_data[15:0]};
      K_RD1:   return {16'h0, rd_data[31:16]};
      K_PD0:   return {31'h0, rd_pending[0]};
      K_PD1:   return {31'h0, rd_pending[1]};
      K_BUSY:  return {31'h0, clr_busy};
      K_DONE:  return {31'h0, clr_done};
      K2_BUSY: return {31'h0, clr_busy2};
      K2_DONE: return {31'h0, clr_done2};
      default: begin
        if (k >= K2_RD0 && k < K2_RD0 + 4) return rd_data2[(k-K2_RD0)*32 +: 32];
        if (k >= K2_PD0 && k < K2_PD0 + 4) return {31'h0, rd_pending2[k-K2_PD0]};
        return 32'hDEAD_DEAD;
      end
    endcase
  endfunction

  int          mk;
  logic [31:0] me, ma;
  string       mn;
  always @(negedge clk) begin
    while (kq.size() > 0) begin
      mk = kq.pop_front();
      me = eq.pop_front();
      mn = nq.pop_front();
      ma = actual(mk);
      checks++;
      if (ma !== me) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mn, ma, me);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0; rd_addr2 = '0;
    rsv_en2 = 1'b0; rsv_addr2 = '0; clr_req2 = 1'b0;
    tick(); tick();

    push_chk(K_RD0, 32'h0, "rst_rd0");
    push_chk(K_PD0, 32'h0, "rst_pend0");
    push_chk(K_BUSY, 32'h0, "rst_busy");
    push_chk(K_DONE, 32'h0, "rst_done");
    push_chk(K2_RD0, 32'h0, "rst_u2_rd0");
    nrst = 1'b1;
    tick();

    // Basic write then read
    wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[15:0] = 16'h1234;
    tick();
    wr_en = 2'b00; rd_addr[4:0] = 5'd3;
    push_chk(K_RD0, 32'h1234, "wr_a3");
    push_chk(K_PD0, 32'h0, "pend_a3");
    tick();

    // Same-address collision: port 1 wins, bypass and stored
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {16'h5555, 16'hAAAA};
    rd_addr[9:5] = 5'd5;
    push_chk(K_RD1, 32'h5555, "bypass_prio");
    tick();
    wr_en = 2'b00;
    push_chk(K_RD1, 32'h5555, "store_prio");
    tick();
    wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[15:0] = 16'h0F0F;
    push_chk(K_RD1, 32'h0F0F, "bypass_p0");
    tick();
    wr_en = 2'b00;
    push_chk(K_RD1, 32'h0F0F, "store_p0");
    push_chk(K_RD0, 32'h1234, "keep_a3");
    tick();

    // Pending scoreboard on addr 7
    rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr[4:0] = 5'd7;
    push_chk(K_PD0, 32'h0, "pend_nobypass");
    tick();
    rsv_en = 1'b0;
    push_chk(K_PD0, 32'h1, "pend_set");
    wr_en = 2'b01; wr_addr[4:0] = 5'd7; wr_data[15:0] = 16'h00FF;
    tick();
    wr_en = 2'b00;
    push_chk(K_PD0, 32'h0, "pend_clr");
    push_chk(K_RD0, 32'h00FF, "rd_a7");
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    wr_en = 2'b10; wr_addr[9:5] = 5'd7; wr_data[31:16] = 16'h00FF;
    tick();
    rsv_en = 1'b0; wr_en = 2'b00;
    push_chk(K_PD0, 32'h1, "pend_rsv_wr");
    push_chk(K_RD0, 32'h00FF, "rd_rsv_wr");
    tick();

    // Fill all registers
    for (int i = 0; i < 32; i++) begin
      wr_en = 2'b01; wr_addr[4:0] = 5'(i); wr_data[15:0] = 16'hA000 + 16'(i);
      tick();
    end
    wr_en = 2'b00; rd_addr[4:0] = 5'd31;
    push_chk(K_RD0, 32'hA01F, "fill_a31");
    // Clear request together with an accepted write and reservation
    clr_req = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd7;
    wr_en = 2'b01; wr_addr[4:0] = 5'd2; wr_data[15:0] = 16'hBEEF;
    tick();
    clr_req = 1'b0;

    for (int c = 0; c < 32; c++) begin
      wr_en = 2'b11; wr_addr = {5'd7, 5'd31}; wr_data = 32'hFFFF_FFFF;
      rsv_en = 1'b1; rsv_addr = 5'd31;
      clr_req = (c == 5 || c == 31);
      rd_addr = {5'd7, (c == 0) ? 5'd2 : 5'd31};
      push_chk(K_BUSY, 32'h1, "busy");
      push_chk(K_DONE, 32'h0, "no_done");
      push_chk(K_RD0, (c == 0) ? 32'hBEEF : 32'hA01F, "rd_during_clr");
      push_chk(K_PD1, (c <= 7) ? 32'h1 : 32'h0, "pend7_clr");
      push_chk(K_RD1, (c <= 7) ? 32'hA007 : 32'h0, "rd7_clr");
      tick();
    end
    wr_en = 2'b00; rsv_en = 1'b0; clr_req = 1'b0;
    push_chk(K_BUSY, 32'h0, "busy_end");
    push_chk(K_DONE, 32'h1, "done_pulse");
    tick();
    push_chk(K_DONE, 32'h0, "done_once");
    push_chk(K_BUSY, 32'h0, "no_restart");
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd31, 5'(a)};
      push_chk(K_RD0, 32'h0, "clr_zero");
      push_chk(K_PD0, 32'h0, "clr_pend0");
      push_chk(K_PD1, 32'h0, "pend31");
      tick();
    end

    // Reset in the middle of a clear
    wr_en = 2'b01; wr_addr[4:0] = 5'd20; wr_data[15:0] = 16'h2020;
    tick();
    wr_addr[4:0] = 5'd1; wr_data[15:0] = 16'h1111;
    tick();
    wr_en = 2'b00; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      push_chk(K_BUSY, 32'h1, "busy_pre_rst");
      tick();
    end
    nrst = 1'b0; clr_req = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd20;
    wr_en = 2'b01; wr_addr[4:0] = 5'd20; wr_data[15:0] = 16'hDEAD;
    push_chk(K_BUSY, 32'h1, "busy_c10");
    tick();
    nrst = 1'b1; clr_req = 1'b0; rsv_en = 1'b0; wr_en = 2'b00;
    rd_addr = {5'd20, 5'd20};
    push_chk(K_BUSY, 32'h0, "rst_abort");
    push_chk(K_DONE, 32'h0, "rst_nodone");
    push_chk(K_RD0, 32'h0, "rst_zero20");
    push_chk(K_PD1, 32'h0, "rst_pend20");
    tick();
    push_chk(K_DONE, 32'h0, "rst_nodone2");
    push_chk(K_BUSY, 32'h0, "rst_idle2");
    wr_en = 2'b01; wr_addr[4:0] = 5'd4; wr_data[15:0] = 16'h4444;
    tick();
    wr_en = 2'b00; rd_addr[4:0] = 5'd4;
    push_chk(K_RD0, 32'h4444, "post_rst_wr");
    tick();

    // Wide build: 24 registers, 3 write ports, 4 read ports
    wr_en2 = 3'b111;
    wr_addr2 = {5'd30, 5'd10, 5'd23};
    wr_data2 = {32'h1234_5678, 32'h1111_2222, 32'hCAFE_BABE};
    rd_addr2 = {5'd30, 5'd0, 5'd0, 5'd23};
    rsv_en2 = 1'b1; rsv_addr2 = 5'd30;
    push_chk(K2_RD0 + 3, 32'h0, "u2_byp_oor");
    push_chk(K2_RD0, 32'hCAFE_BABE, "u2_byp23");
    tick();
    wr_en2 = 3'b101;
    wr_addr2 = {5'd10, 5'd0, 5'd10};
    wr_data2 = {32'hBBBB_BBBB, 32'h0, 32'hAAAA_AAAA};
    rsv_en2 = 1'b1; rsv_addr2 = 5'd23;
    rd_addr2 = {5'd30, 5'd10, 5'd30, 5'd23};
    push_chk(K2_RD0, 32'hCAFE_BABE, "u2_a23");
    push_chk(K2_RD0 + 1, 32'h0, "u2_a30");
    push_chk(K2_RD0 + 2, 32'hBBBB_BBBB, "u2_byp_prio3");
    push_chk(K2_PD0 + 1, 32'h0, "u2_rsv_oor");
    tick();
    wr_en2 = 3'b000; rsv_en2 = 1'b0;
    push_chk(K2_RD0 + 2, 32'hBBBB_BBBB, "u2_prio3");
    push_chk(K2_PD0, 32'h1, "u2_pend23");
    push_chk(K2_PD0 + 3, 32'h0, "u2_pend30");
    push_chk(K2_BUSY, 32'h0, "u2_busy");
    push_chk(K2_DONE, 32'h0, "u2_done");
    tick();

    @(negedge clk);
    #1;
    if (kq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", kq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
